// File: rtl/axis_pixel_unpacker.sv
// axis_pixel_unpacker
// Unpacks AXI-Stream beats of PPB packed {R,G,B} pixels into a
// one-pixel-per-cycle valid/ready stream with raster markers.
// The markers come from internal counters, not from the input framing.
// Input framing (tlast/tkeep) is checked against the configured geometry.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   s_axis_*          input beat stream (tvalid/tready/tdata/tkeep/tlast)
//   pix_valid/ready   output pixel handshake
//   pix_data          pixel, bit layout unchanged from the input lane
//   pix_sol/eol       first/last pixel of a line (qualified by pix_valid)
//   pix_sof/eof       first/last pixel of a frame (qualified by pix_valid)
//   err_clr           synchronous clear of the sticky error flags
//   err_tlast         sticky: tlast disagreed with the expected line end
//   err_keep          sticky: an accepted beat had tkeep != all-ones
module axis_pixel_unpacker #(
  parameter int AXIS_DATA_WIDTH = 96,
  parameter int AXIS_STRB_WIDTH = 12,
  parameter int CH_WIDTH        = 8,
  parameter int IMAGE_WIDTH     = 3840,
  parameter int IMAGE_HEIGHT    = 100
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [AXIS_STRB_WIDTH-1:0] s_axis_tkeep,
  input  logic                       s_axis_tlast,
  output logic                       pix_valid,
  input  logic                       pix_ready,
  output logic [3*CH_WIDTH-1:0]      pix_data,
  output logic                       pix_sol,
  output logic                       pix_eol,
  output logic                       pix_sof,
  output logic                       pix_eof,
  input  logic                       err_clr,
  output logic                       err_tlast,
  output logic                       err_keep
);

  localparam int PIX_W = 3 * CH_WIDTH;
  localparam int PPB   = AXIS_DATA_WIDTH / PIX_W;
  localparam int IW    = (PPB > 1) ? $clog2(PPB) : 1;
  localparam int XW    = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
  localparam int YW    = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;

  localparam logic [IW-1:0] IDX_LAST    = IW'(PPB - 1);
  localparam logic [XW-1:0] X_LAST      = XW'(IMAGE_WIDTH - 1);
  localparam logic [XW-1:0] X_LAST_BEAT = XW'(IMAGE_WIDTH - PPB);
  localparam logic [YW-1:0] Y_LAST      = YW'(IMAGE_HEIGHT - 1);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_DRAIN = 1'b1
  } state_t;

  state_t                     state_q, state_d;
  logic [AXIS_DATA_WIDTH-1:0] beat_q, beat_d;
  logic [IW-1:0]              idx_q, idx_d;
  logic [XW-1:0]              x_q, x_d;
  logic [YW-1:0]              y_q, y_d;
  logic                       err_tlast_q, err_tlast_d;
  logic                       err_keep_q, err_keep_d;

  logic                       pix_fire;
  logic                       beat_fire;
  logic                       last_pix;
  logic                       tlast_bad;
  logic                       keep_bad;

  // Split the holding register into pixel lanes; the output mux picks one.
  logic [PIX_W-1:0] lane [PPB];

  for (genvar gi = 0; gi < PPB; gi++) begin : g_lane
    assign lane[gi] = beat_q[gi*PIX_W +: PIX_W];
  end

  assign pix_valid = (state_q == S_DRAIN);
  assign pix_data  = lane[idx_q];
  assign last_pix  = (state_q == S_DRAIN) && (idx_q == IDX_LAST);

  // The only combinational pix_ready -> s_axis_tready path: while the last
  // pixel of the buffered beat is being consumed, the next beat may load.
  assign s_axis_tready = (state_q == S_EMPTY) || (last_pix && pix_ready);

  assign pix_fire  = pix_valid && pix_ready;
  assign beat_fire = s_axis_tvalid && s_axis_tready;

  assign pix_sol = pix_valid && (x_q == '0);
  assign pix_eol = pix_valid && (x_q == X_LAST);
  assign pix_sof = pix_sol && (y_q == '0);
  assign pix_eof = pix_eol && (y_q == Y_LAST);

  assign err_tlast = err_tlast_q;
  assign err_keep  = err_keep_q;

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    idx_d     = idx_q;
    x_d       = x_q;
    y_d       = y_q;
    tlast_bad = 1'b0;
    keep_bad  = 1'b0;

    if (pix_fire) begin
      idx_d = idx_q + 1'b1;
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
      if (last_pix) begin
        idx_d   = '0;
        state_d = S_EMPTY;
      end
    end

    if (beat_fire) begin
      beat_d  = s_axis_tdata;
      idx_d   = '0;
      state_d = S_DRAIN;
      // x_d already points at the column of this beat's first pixel, both
      // when loading from EMPTY and when loading behind a last-pixel consume.
      tlast_bad = (s_axis_tlast != (x_d == X_LAST_BEAT));
      keep_bad  = (s_axis_tkeep != '1);
    end

    // A new error in the same cycle as err_clr keeps the flag set.
    err_tlast_d = (err_tlast_q && !err_clr) || tlast_bad;
    err_keep_d  = (err_keep_q && !err_clr) || keep_bad;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_EMPTY;
      beat_q      <= '0;
      idx_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      err_tlast_q <= 1'b0;
      err_keep_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      idx_q       <= idx_d;
      x_q         <= x_d;
      y_q         <= y_d;
      err_tlast_q <= err_tlast_d;
      err_keep_q  <= err_keep_d;
    end
  end

endmodule

// File: tb/tb_axis_pixel_unpacker.sv
// tb_axis_pixel_unpacker
// Directed bench for axis_pixel_unpacker on an 8x2 image: table-driven
// beat/pixel vectors run through a cycle loop, plus hand-written sequences
// for tlast/tkeep errors, err_clr and reset in the middle of a beat.
module tb_axis_pixel_unpacker;

  localparam int DW = 96;
  localparam int SW = 12;
  localparam int CW = 8;
  localparam int W  = 8;
  localparam int H  = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic [DW-1:0] s_axis_tdata = '0;
  logic [SW-1:0] s_axis_tkeep = '1;
  logic          s_axis_tlast = 1'b0;
  logic          pix_valid;
  logic          pix_ready = 1'b0;
  logic [23:0]   pix_data;
  logic          pix_sol, pix_eol, pix_sof, pix_eof;
  logic          err_clr = 1'b0;
  logic          err_tlast, err_keep;

  axis_pixel_unpacker #(
    .AXIS_DATA_WIDTH(DW),
    .AXIS_STRB_WIDTH(SW),
    .CH_WIDTH       (CW),
    .IMAGE_WIDTH    (W),
    .IMAGE_HEIGHT   (H)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tkeep (s_axis_tkeep),
    .s_axis_tlast (s_axis_tlast),
    .pix_valid    (pix_valid),
    .pix_ready    (pix_ready),
    .pix_data     (pix_data),
    .pix_sol      (pix_sol),
    .pix_eol      (pix_eol),
    .pix_sof      (pix_sof),
    .pix_eof      (pix_eof),
    .err_clr      (err_clr),
    .err_tlast    (err_tlast),
    .err_keep     (err_keep)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [SW-1:0] keep;
    logic          last;
  } beat_t;

  typedef struct {
    logic [23:0] data;
    logic        sol;
    logic        eol;
    logic        sof;
    logic        eof;
  } pix_t;

  beat_t beat_q[$];
  pix_t  exp_q[$];
  int    checks = 0;
  int    errors = 0;

  function automatic logic [23:0] pv(input int n);
    logic [7:0] b;
    b = 8'(n);
    return {8'h5A, b, ~b};
  endfunction

  function automatic logic [DW-1:0] mkbeat(input int n);
    return {pv(n + 3), pv(n + 2), pv(n + 1), pv(n)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add_beat(input logic [DW-1:0] d, input logic [SW-1:0] k, input logic l);
    beat_t b;
    b.data = d; b.keep = k; b.last = l;
    beat_q.push_back(b);
  endtask

  task automatic add_exp(input logic [23:0] d, input logic sol, input logic eol,
                         input logic sof, input logic eof);
    pix_t p;
    p.data = d; p.sol = sol; p.eol = eol; p.sof = sof; p.eof = eof;
    exp_q.push_back(p);
  endtask

  // Called at a negedge. Presents beat_q, consumes and checks exp_q.
  // stall_en holds pix_ready low for two cycles on pixels 2 and 3.
  task automatic run(input string name, input bit no_bubble, input bit stall_en);
    int bi = 0;
    int pi = 0;
    int cyc = 0;
    int held = 0;
    int first = -1;
    int last = -1;
    while (pi < exp_q.size() && cyc < 300) begin
      if (bi < beat_q.size()) begin
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = beat_q[bi].data;
        s_axis_tkeep  = beat_q[bi].keep;
        s_axis_tlast  = beat_q[bi].last;
      end else begin
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '1;
        s_axis_tlast  = 1'b0;
      end
      pix_ready = !(stall_en && (pi == 2 || pi == 3) && held < 2);
      #1;
      if (pix_valid && !pix_ready) begin
        held++;
        chk({name, "_stall_data"}, 32'(pix_data), 32'(exp_q[pi].data));
        chk({name, "_stall_tready"}, 32'(s_axis_tready), 32'd0);
      end
      if (pix_valid && pix_ready) begin
        $display("%s pix %0d data=%h sol=%b eol=%b sof=%b eof=%b", name, pi,
                 pix_data, pix_sol, pix_eol, pix_sof, pix_eof);
        chk({name, "_data"}, 32'(pix_data), 32'(exp_q[pi].data));
        chk({name, "_markers"}, 32'({pix_sol, pix_eol, pix_sof, pix_eof}),
            32'({exp_q[pi].sol, exp_q[pi].eol, exp_q[pi].sof, exp_q[pi].eof}));
        if (first < 0) first = cyc;
        last = cyc;
        pi++;
        held = 0;
      end
      if (s_axis_tvalid && s_axis_tready) bi++;
      @(negedge clk);
      cyc++;
    end
    s_axis_tvalid = 1'b0;
    pix_ready     = 1'b0;
    chk({name, "_pixels_seen"}, 32'(pi), 32'(exp_q.size()));
    chk({name, "_beats_taken"}, 32'(bi), 32'(beat_q.size()));
    if (no_bubble) chk({name, "_no_bubble_span"}, 32'(last - first), 32'(exp_q.size() - 1));
    beat_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_pix_valid", 32'(pix_valid), 32'd0);
    chk("rst_tready", 32'(s_axis_tready), 32'd1);
    chk("rst_pix_data", 32'(pix_data), 32'd0);
    chk("rst_markers", 32'({pix_sol, pix_eol, pix_sof, pix_eof}), 32'd0);
    chk("rst_errs", 32'({err_tlast, err_keep}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Continuous stream: frame of 2 lines, then one more full line that
    // starts the next frame. tlast on the second beat of each line.
    for (int b = 0; b < 6; b++) add_beat(mkbeat(4 * b), 12'hFFF, (b == 1 || b == 3 || b == 5));
    for (int n = 0; n < 24; n++)
      add_exp(pv(n), (n == 0 || n == 8 || n == 16), (n == 7 || n == 15 || n == 23),
              (n == 0 || n == 16), (n == 15));
    run("cont", 1'b1, 1'b0);
    chk("cont_errs", 32'({err_tlast, err_keep}), 32'd0);

    // Backpressure on second line of the frame (y=1)
    add_beat(mkbeat(24), 12'hFFF, 1'b0);
    add_beat(mkbeat(28), 12'hFFF, 1'b1);
    for (int n = 24; n < 32; n++)
      add_exp(pv(n), (n == 24), (n == 31), 1'b0, (n == 31));
    run("bp", 1'b0, 1'b1);
    chk("bp_errs", 32'({err_tlast, err_keep}), 32'd0);

    // tlast on the first beat of a line; pixel left undrained to inspect it
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = mkbeat(32);
    s_axis_tkeep  = 12'hFFF;
    s_axis_tlast  = 1'b1;
    pix_ready     = 1'b0;
    #1;
    chk("tl_tready_empty", 32'(s_axis_tready), 32'd1);
    chk("tl_err_before", 32'(err_tlast), 32'd0);
    @(posedge clk);
    #1;
    $display("tl beat accepted err_tlast=%b", err_tlast);
    chk("tl_err_after", 32'(err_tlast), 32'd1);
    chk("tl_pix_valid", 32'(pix_valid), 32'd1);
    chk("tl_markers", 32'({pix_sol, pix_eol, pix_sof, pix_eof}), 32'b1010);
    chk("tl_data", 32'(pix_data), 32'(pv(32)));
    @(negedge clk);
    add_beat(mkbeat(36), 12'hFFF, 1'b1);
    for (int n = 32; n < 40; n++)
      add_exp(pv(n), (n == 32), (n == 39), (n == 32), 1'b0);
    run("tl", 1'b0, 1'b0);
    chk("tl_err_sticky", 32'(err_tlast), 32'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    #1;
    chk("tl_err_cleared", 32'(err_tlast), 32'd0);
    @(negedge clk);

    // tkeep error on one beat; data still emitted verbatim
    add_beat(mkbeat(40), 12'h0FF, 1'b0);
    add_beat(mkbeat(44), 12'hFFF, 1'b1);
    for (int n = 40; n < 48; n++)
      add_exp(pv(n), (n == 40), (n == 47), 1'b0, (n == 47));
    run("keep", 1'b0, 1'b0);
    chk("keep_err", 32'(err_keep), 32'd1);
    chk("keep_tlast_clean", 32'(err_tlast), 32'd0);

    // Reset with idx=2
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = mkbeat(48);
    s_axis_tkeep  = 12'hFFF;
    s_axis_tlast  = 1'b0;
    pix_ready     = 1'b0;
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    pix_ready     = 1'b1;
    repeat (2) @(negedge clk);
    pix_ready = 1'b0;
    #1;
    chk("mr_valid_pre", 32'(pix_valid), 32'd1);
    chk("mr_data_idx2", 32'(pix_data), 32'(pv(50)));
    rst_n = 1'b0;
    #1;
    $display("mr reset asserted pix_valid=%b", pix_valid);
    chk("mr_valid_now", 32'(pix_valid), 32'd0);
    chk("mr_tready", 32'(s_axis_tready), 32'd1);
    chk("mr_data", 32'(pix_data), 32'd0);
    chk("mr_err_keep", 32'(err_keep), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    add_beat(mkbeat(100), 12'hFFF, 1'b0);
    for (int n = 100; n < 104; n++)
      add_exp(pv(n), (n == 100), 1'b0, (n == 100), 1'b0);
    run("mr", 1'b0, 1'b0);
    chk("mr_errs", 32'({err_tlast, err_keep}), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
